// File: rtl/booth_csa_accumulator_if.sv
// rtl/booth_csa_accumulator_if.sv - operand/product handshake bundle for the Booth CSA accumulator
interface booth_csa_accumulator_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] carry;

  // Producer of operands / consumer of products
  modport master (
    output in_valid, signed_mode, a, b, out_ready,
    input  in_ready, out_valid, sum, carry
  );

  // The accumulator itself
  modport slave (
    input  in_valid, signed_mode, a, b, out_ready,
    output in_ready, out_valid, sum, carry
  );
endinterface

// File: rtl/booth_csa_accumulator.sv
// rtl/booth_csa_accumulator.sv - iterative radix-4 Booth multiplier into a carry-save accumulator
module booth_csa_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  booth_csa_accumulator_if.slave bus
);
  localparam int D  = WIDTH / 2 + 1;   // Booth digits over the (WIDTH+2)-bit extended multiplier
  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [PW-1:0]   a_sh;      // multiplicand, sign-extended, pre-shifted by 2*count
  logic [EW:0]     b_sh;      // extended multiplier with the implicit b[-1]=0 at bit 0
  logic [PW-1:0]   sum_q, carry_q;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   sum_nx, carry_nx;
  logic [EW-1:0]   a_ext, b_ext;
  logic            accept, last_digit;

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_digit = (count == CW'(D - 1));

  assign a_ext = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign b_ext = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; inputs outside IDLE/DONE have no effect
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = BUSY;
      BUSY:    if (last_digit)   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Booth digit select: exact two's complement partial product for the current digit
  always_comb begin
    pp = '0;
    case (b_sh[2:0])
      3'b001, 3'b010: pp = a_sh;
      3'b011:         pp = a_sh << 1;
      3'b100:         pp = -(a_sh << 1);
      3'b101, 3'b110: pp = -a_sh;
      default:        pp = '0;
    endcase
  end

  // 3:2 compression of the partial product into the redundant accumulator
  assign sum_nx   = sum_q ^ carry_q ^ pp;
  assign carry_nx = ((sum_q & carry_q) | (sum_q & pp) | (carry_q & pp)) << 1;

  // Datapath: load operands on accept, retire one digit per BUSY cycle, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      count   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
    end else if (accept) begin
      sum_q   <= '0;
      carry_q <= '0;
      count   <= '0;
      a_sh    <= {{(PW-EW){a_ext[EW-1]}}, a_ext};
      b_sh    <= {b_ext, 1'b0};
    end else if (state == BUSY) begin
      sum_q   <= sum_nx;
      carry_q <= carry_nx;
      count   <= count + 1'b1;
      a_sh    <= a_sh << 2;
      b_sh    <= b_sh >> 2;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_booth_csa_accumulator.sv
// tb/tb_booth_csa_accumulator.sv - scoreboard bench for booth_csa_accumulator
module tb_booth_csa_accumulator;
  localparam int W   = 32;
  localparam int LAT = W / 2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   stall_en = 1'b0;

  typedef struct {
    logic [63:0] prod;
    int          acc_cyc;
  } exp_t;
  exp_t sbq[$];

  booth_csa_accumulator_if #(.WIDTH(W)) bus();

  booth_csa_accumulator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: extend per mode, multiply, keep the low 64 bits
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic sm);
    logic [63:0] xe, ye;
    xe = sm ? {{32{x[31]}}, x} : {32'h0, x};
    ye = sm ? {{32{y[31]}}, y} : {32'h0, y};
    return xe * ye;
  endfunction

  // Monitor: first cycle of each out_valid checks product and latency; later cycles check hold
  logic        seen = 1'b0;
  logic [63:0] hold_s, hold_c;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen   = 1'b1;
        hold_s = bus.sum;
        hold_c = bus.carry;
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("product", bus.sum + bus.carry, e.prod);
          chk("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
        end
      end else begin
        chk("hold_sum", bus.sum, hold_s);
        chk("hold_carry", bus.carry, hold_c);
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (stall_en) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sm);
    int n = 0;
    tick();
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
    end else begin
      bus.a = x;
      bus.b = y;
      bus.signed_mode = sm;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      sbq.push_back('{prod: ref_mul(x, y, sm), acc_cyc: cyc});
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      bus.signed_mode = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    tick();
    while (!(sbq.size() == 0 && bus.in_ready) && n < 400) begin
      tick();
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] s0, c0;
    int n;
    bus.in_valid = 1'b0;
    bus.signed_mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", bus.sum, 64'd0);
    chk("rst_carry", bus.carry, 64'd0);
    rst = 1'b0;

    // Directed corner products
    issue(32'd3, 32'd5, 1'b0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(32'h80000000, 32'h80000000, 1'b1);
    issue(32'h80000000, 32'h7FFFFFFF, 1'b1);
    issue(32'h00000000, 32'hDEADBEEF, 1'b1);
    drain();

    // Backpressure in DONE with ignored in_valid pulses
    bus.out_ready = 1'b0;
    issue(32'd123456789, 32'd987654321, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 64'(bus.out_valid), 64'd1);
    s0 = bus.sum;
    c0 = bus.carry;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'($urandom);
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_sum", bus.sum, s0);
      chk("bp_carry", bus.carry, c0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_sum", bus.sum, s0);
    chk("bp_release_carry", bus.carry, c0);
    drain();

    // Reset mid-product at count=5
    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_sum", bus.sum, 64'd0);
    chk("arst_carry", bus.carry, 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    issue(32'd7, 32'd6, 1'b0);
    drain();

    // Random operands and modes with random out_ready stalls
    stall_en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 7))
        0:       issue(32'hFFFFFFFF, $urandom, 1'($urandom));
        1:       issue(32'h80000000, $urandom, 1'($urandom));
        default: issue($urandom, $urandom, 1'($urandom));
      endcase
    end
    drain();
    stall_en = 1'b0;
    bus.out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
